// File: rtl/ir_rx_letter_buffer.sv
// ir_rx_letter_buffer
// Receive-side letter buffer between the IR decoder and the Enigma decoder.
// Letter codes (0..MAX_CODE) strobed in by the IR decoder are queued in a
// FIFO and handed to the Enigma decoder one at a time, with HOLDOFF idle
// cycles after each issued letter. Out-of-range codes and overflow writes
// are dropped and counted.
//
// Optional build macro: IR_RX_ERR_FLUSH_EN
//   When defined, any cycle with error_in != 0 flushes the FIFO and the
//   discarded entries are added to the drop counter. When undefined,
//   error_in is ignored.
module ir_rx_letter_buffer #(
  parameter int DEPTH    = 64,
  parameter int HOLDOFF  = 8,
  parameter int MAX_CODE = 25,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [4:0]        code_in,
  input  logic              code_valid_in,
  input  logic [2:0]        error_in,
  input  logic              dec_ready_in,
  output logic [4:0]        data_out,
  output logic              data_valid_out,
  output logic [ADDR_W:0]   count_out,
  output logic              full_out,
  output logic              empty_out,
  output logic [7:0]        drop_count_out,
  output logic [15:0]       letter_count_out
);

  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO   = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [4:0]        MAX_CODE_C = 5'(MAX_CODE);
  localparam logic [7:0]        HOLDOFF_C  = 8'(HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // storage and bookkeeping registers
  logic [4:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              full_r;
  logic              empty_r;
  logic [4:0]        data_r;
  logic              valid_r;
  logic [7:0]        drop_cnt_r;
  logic [15:0]       letter_cnt_r;
  state_t            state_r;
  logic [7:0]        hold_cnt_r;

  // next-state / control signals
  state_t            state_nxt_s;
  logic [7:0]        hold_cnt_nxt_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic              flush_s;
  logic              code_ok_s;
  logic [ADDR_W:0]   count_nxt_s;
  logic [ADDR_W:0]   discard_s;
  logic [15:0]       drop_sum_s;
  logic [7:0]        drop_cnt_nxt_s;

`ifdef IR_RX_ERR_FLUSH_EN
  assign flush_s = (error_in != 3'd0);
`else
  // error_in is intentionally ignored in this build
  logic unused_err_s;
  assign unused_err_s = ^error_in;
  assign flush_s      = 1'b0;
`endif

  assign code_ok_s = (code_in <= MAX_CODE_C);

  // issue FSM: pop in IDLE, one-cycle strobe in ISSUE, paced wait in HOLD
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if ((count_r != CNT_ZERO) && dec_ready_in) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        hold_cnt_nxt_s = HOLDOFF_C;
        state_nxt_s    = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt_r <= 8'd1) begin
          hold_cnt_nxt_s = 8'd0;
          state_nxt_s    = ST_IDLE;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 8'd1;
          state_nxt_s    = ST_HOLD;
        end
      end
      default: begin
        hold_cnt_nxt_s = 8'd0;
        state_nxt_s    = ST_IDLE;
      end
    endcase
  end

  // write acceptance: a full FIFO still accepts when a pop frees a slot this cycle
  always_comb begin
    push_s = 1'b0;
    drop_s = 1'b0;
    if (code_valid_in) begin
      if (flush_s) begin
        drop_s = 1'b1;
      end else if (!code_ok_s) begin
        drop_s = 1'b1;
      end else if ((count_r == DEPTH_C) && !pop_s) begin
        drop_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
      drop_s = 1'b0;
    end
  end

  // occupancy update and flush discard accounting
  always_comb begin
    count_nxt_s = count_r;
    discard_s   = CNT_ZERO;
    if (flush_s) begin
      count_nxt_s = CNT_ZERO;
      // a letter popped in the flush cycle is issued, not discarded
      discard_s   = pop_s ? (count_r - CNT_ONE) : count_r;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // saturating drop counter next value
  always_comb begin
    drop_sum_s = {8'd0, drop_cnt_r} + 16'(discard_s) + 16'(drop_s);
    if (drop_sum_s > 16'd255) begin
      drop_cnt_nxt_s = 8'd255;
    end else begin
      drop_cnt_nxt_s = drop_sum_s[7:0];
    end
  end

  // FIFO storage write port (contents need no reset)
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= code_in;
    end
  end

  // control, pointer, counter and output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= 8'd0;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      count_r      <= CNT_ZERO;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      data_r       <= 5'd0;
      valid_r      <= 1'b0;
      drop_cnt_r   <= 8'd0;
      letter_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == DEPTH_C);
      empty_r    <= (count_nxt_s == CNT_ZERO);
      valid_r    <= (state_nxt_s == ST_ISSUE);
      drop_cnt_r <= drop_cnt_nxt_s;
      if (flush_s) begin
        wr_ptr_r <= PTR_ZERO;
        rd_ptr_r <= PTR_ZERO;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      if (pop_s) begin
        data_r <= mem_r[rd_ptr_r];
      end
      if (push_s) begin
        letter_cnt_r <= letter_cnt_r + 16'd1;
      end
    end
  end

  assign data_out         = data_r;
  assign data_valid_out   = valid_r;
  assign count_out        = count_r;
  assign full_out         = full_r;
  assign empty_out        = empty_r;
  assign drop_count_out   = drop_cnt_r;
  assign letter_count_out = letter_cnt_r;

endmodule

// File: tb/tb_ir_rx_letter_buffer.sv
// Directed self-checking bench for ir_rx_letter_buffer (DEPTH=64, HOLDOFF=8).
// Honours IR_RX_ERR_FLUSH_EN for the error-flush scenario.
module tb_ir_rx_letter_buffer;

  localparam int DEPTH = 64;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [4:0]  code_in;
  logic        code_valid_in;
  logic [2:0]  error_in;
  logic        dec_ready_in;
  logic [4:0]  data_out;
  logic        data_valid_out;
  logic [6:0]  count_out;
  logic        full_out;
  logic        empty_out;
  logic [7:0]  drop_count_out;
  logic [15:0] letter_count_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;
  logic prev_v = 1'b0;
  logic [4:0] pv[$];
  int pc[$];

  ir_rx_letter_buffer #(.DEPTH(64), .HOLDOFF(8), .MAX_CODE(25)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .code_in          (code_in),
    .code_valid_in    (code_valid_in),
    .error_in         (error_in),
    .dec_ready_in     (dec_ready_in),
    .data_out         (data_out),
    .data_valid_out   (data_valid_out),
    .count_out        (count_out),
    .full_out         (full_out),
    .empty_out        (empty_out),
    .drop_count_out   (drop_count_out),
    .letter_count_out (letter_count_out)
  );

  always #5 clk_in = ~clk_in;

  // cycle counter for pulse timing
  always @(posedge clk_in) cyc <= cyc + 1;

  // capture every issued letter and forbid back-to-back strobes
  always @(negedge clk_in) begin
    if (rst_in === 1'b1 && data_valid_out === 1'b1) begin
      checks++;
      assert (prev_v === 1'b0) else begin
        errors++;
        $error("FAIL back_to_back_valid observed=%0d expected=0", prev_v);
      end
      pv.push_back(data_out);
      pc.push_back(cyc);
    end
    prev_v = (rst_in === 1'b1) ? data_valid_out : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic strobe(input logic [4:0] c);
    code_in       = c;
    code_valid_in = 1'b1;
    tick(1);
    code_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1;
    rst_in        = 1'b0;
    code_in       = 5'd0;
    code_valid_in = 1'b0;
    error_in      = 3'd0;
    dec_ready_in  = 1'b0;
    tick(2);
    rst_in = 1'b1;
    pv.delete();
    pc.delete();
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_data"},   32'(data_out), 32'd0);
    chk({p, "_valid"},  32'(data_valid_out), 32'd0);
    chk({p, "_count"},  32'(count_out), 32'd0);
    chk({p, "_full"},   32'(full_out), 32'd0);
    chk({p, "_empty"},  32'(empty_out), 32'd1);
    chk({p, "_drop"},   32'(drop_count_out), 32'd0);
    chk({p, "_letter"}, 32'(letter_count_out), 32'd0);
  endtask

  function automatic logic [31:0] pget(input int i);
    return (i < pv.size()) ? 32'(pv[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] cget(input int i);
    return (i < pc.size()) ? 32'(pc[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst_in        = 1'b0;
    code_in       = 5'd0;
    code_valid_in = 1'b0;
    error_in      = 3'd0;
    dec_ready_in  = 1'b0;
    tick(1);
    chk_reset("rst_hold");
    rst_in = 1'b1;
    tick(1);
    chk_reset("rst_rel");

    // H, E, L spaced 3 cycles apart
    do_reset();
    dec_ready_in = 1'b1;
    c0 = cyc;
    strobe(5'd7);
    tick(2);
    strobe(5'd4);
    tick(2);
    strobe(5'd11);
    tick(40);
    chk("hel_npulses", 32'(pv.size()), 32'd3);
    chk("hel_l0", pget(0), 32'd7);
    chk("hel_l1", pget(1), 32'd4);
    chk("hel_l2", pget(2), 32'd11);
    chk("hel_lat", cget(0) - 32'(c0), 32'd2);
    chk("hel_gap1", cget(1) - cget(0), 32'd10);
    chk("hel_gap2", cget(2) - cget(1), 32'd10);
    chk("hel_letters", 32'(letter_count_out), 32'd3);
    chk("hel_empty", 32'(empty_out), 32'd1);

    // invalid codes 30 and 26 are dropped, 0 is accepted
    do_reset();
    dec_ready_in = 1'b1;
    strobe(5'd30);
    tick(2);
    strobe(5'd26);
    tick(2);
    strobe(5'd0);
    tick(20);
    chk("inv_drop", 32'(drop_count_out), 32'd2);
    chk("inv_letters", 32'(letter_count_out), 32'd1);
    chk("inv_npulses", 32'(pv.size()), 32'd1);
    chk("inv_l0", pget(0), 32'd0);

    // overflow: DEPTH+3 writes with ready low, then drain in order
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) strobe(5'(i % 26));
    tick(1);
    chk("ovf_full", 32'(full_out), 32'd1);
    chk("ovf_count", 32'(count_out), 32'd64);
    chk("ovf_drop", 32'(drop_count_out), 32'd3);
    chk("ovf_letters", 32'(letter_count_out), 32'd64);
    chk("ovf_empty", 32'(empty_out), 32'd0);
    pv.delete();
    pc.delete();
    dec_ready_in = 1'b1;
    tick(DEPTH * 10 + 20);
    chk("drain_npulses", 32'(pv.size()), 32'd64);
    for (int i = 0; i < DEPTH; i++) chk($sformatf("drain_l%0d", i), pget(i), 32'(i % 26));
    chk("drain_empty", 32'(empty_out), 32'd1);
    chk("drain_count", 32'(count_out), 32'd0);

    // full FIFO: pop and write in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) strobe(5'(i % 26));
    chk("fpw_full_pre", 32'(full_out), 32'd1);
    pv.delete();
    pc.delete();
    code_in       = 5'd5;
    code_valid_in = 1'b1;
    dec_ready_in  = 1'b1;
    tick(1);
    code_valid_in = 1'b0;
    dec_ready_in  = 1'b0;
    chk("fpw_count", 32'(count_out), 32'd64);
    chk("fpw_full", 32'(full_out), 32'd1);
    chk("fpw_drop", 32'(drop_count_out), 32'd0);
    chk("fpw_letters", 32'(letter_count_out), 32'd65);
    tick(20);
    chk("fpw_npulses", 32'(pv.size()), 32'd1);
    chk("fpw_l0", pget(0), 32'd0);

    // asynchronous reset during HOLD with 5 entries queued
    do_reset();
    for (int i = 1; i <= 6; i++) strobe(5'(i));
    dec_ready_in = 1'b1;
    tick(1);
    dec_ready_in = 1'b0;
    tick(3);
    chk("mrst_count_pre", 32'(count_out), 32'd5);
    #1;
    rst_in = 1'b0;
    #1;
    chk_reset("mrst");
    tick(2);
    rst_in = 1'b1;
    pv.delete();
    pc.delete();
    dec_ready_in = 1'b1;
    tick(30);
    chk("mrst_npulses", 32'(pv.size()), 32'd0);
    chk("mrst_empty", 32'(empty_out), 32'd1);

    // drop counter saturation
    do_reset();
    code_in       = 5'd31;
    code_valid_in = 1'b1;
    tick(260);
    code_valid_in = 1'b0;
    tick(1);
    chk("sat_drop", 32'(drop_count_out), 32'd255);
    chk("sat_letters", 32'(letter_count_out), 32'd0);

    // error pulse with 4 letters queued
    do_reset();
    for (int i = 0; i < 4; i++) strobe(5'(i + 1));
    tick(1);
    error_in = 3'b010;
    tick(1);
    error_in = 3'd0;
    tick(1);
`ifdef IR_RX_ERR_FLUSH_EN
    chk("err_count", 32'(count_out), 32'd0);
    chk("err_drop", 32'(drop_count_out), 32'd4);
    chk("err_empty", 32'(empty_out), 32'd1);
`else
    chk("err_count", 32'(count_out), 32'd4);
    chk("err_drop", 32'(drop_count_out), 32'd0);
    chk("err_empty", 32'(empty_out), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
